vga_capture: RTL

- Receive-side counterpart of the VGA sync/pixel generator: samples an incoming VGA stream (sync pulses plus 24-bit RGB) on the pixel clock.
- Recovers column and row position from the sync edges and writes a rectangular window of pixels into a frame memory through a simple write port.
- Used for loopback capture and self-check of the display path, and measures line length as a link-health indicator.

---
 rtl/vga_capture.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/vga_capture.sv
// Samples an incoming VGA stream and writes a rectangular pixel window into
// a frame memory through a simple write port; also reports measured line length.
module vga_capture #(
    parameter int unsigned WIN_X0    = 396,
    parameter int unsigned WIN_W     = 149,
    parameter int unsigned WIN_Y0    = 197,
    parameter int unsigned WIN_H     = 149,
    parameter logic [31:0] BASE_ADDR = 32'd24
) (
    input  logic        VGA_CLK_IN,
    input  logic        i_rst_n,
    input  logic        i_hsync,
    input  logic        i_vsync,
    input  logic [7:0]  i_red,
    input  logic [7:0]  i_green,
    input  logic [7:0]  i_blue,
    input  logic        i_arm,
    input  logic        i_continuous,
    output logic        o_wr_en,
    output logic [31:0] o_wr_addr,
    output logic [23:0] o_wr_data,
    output logic        o_busy,
    output logic        o_frame_done,
    output logic        o_err,
    output logic [9:0]  o_line_len
);

    localparam logic [9:0] X_LO = 10'(WIN_X0);
    localparam logic [9:0] X_HI = 10'(WIN_X0 + WIN_W - 1);
    localparam logic [9:0] Y_LO = 10'(WIN_Y0);
    localparam logic [9:0] Y_HI = 10'(WIN_Y0 + WIN_H - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_VS,
        CAPTURE,
        DONE
    } state_t;

    state_t      state_q;
    logic        hs_q, vs_q, seen_q;
    logic [9:0]  col_q, row_q, len_q;
    logic [31:0] addr_q, wr_addr_q;
    logic [23:0] wr_data_q;
    logic        wr_en_q, done_q, err_q;

    logic        hs_rise, vs_rise;
    logic [9:0]  col_inc, col_d, row_inc, row_d;
    logic        in_win, last_px, cap;
    logic [31:0] base;

    always_comb begin
        hs_rise = i_hsync & ~hs_q;
        vs_rise = i_vsync & ~vs_q;
        col_inc = (col_q == 10'h3FF) ? col_q : col_q + 10'd1;
        row_inc = (row_q == 10'h3FF) ? row_q : row_q + 10'd1;
        col_d   = hs_rise ? 10'd0 : col_inc;
        row_d   = row_q;
        if (vs_rise)
            row_d = 10'd0;
        else if (hs_rise)
            row_d = row_inc;
        in_win  = (col_d >= X_LO) && (col_d <= X_HI)
               && (row_d >= Y_LO) && (row_d <= Y_HI);
        last_px = (col_d == X_HI) && (row_d == Y_HI);
        cap     = (state_q == CAPTURE)
               || ((state_q == WAIT_VS) && vs_rise);
        base    = vs_rise ? BASE_ADDR : addr_q;
    end

    // Position tracking and line measurement run regardless of capture state.
    always_ff @(posedge VGA_CLK_IN or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hs_q   <= 1'b0;
            vs_q   <= 1'b0;
            seen_q <= 1'b0;
            col_q  <= 10'd0;
            row_q  <= 10'd0;
            len_q  <= 10'd0;
        end else begin
            hs_q  <= i_hsync;
            vs_q  <= i_vsync;
            col_q <= col_d;
            row_q <= row_d;
            if (hs_rise) begin
                seen_q <= 1'b1;
                if (seen_q)
                    len_q <= col_inc;
            end
        end
    end

    always_ff @(posedge VGA_CLK_IN or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            addr_q    <= BASE_ADDR;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 32'd0;
            wr_data_q <= 24'd0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (i_arm) begin
                        err_q   <= 1'b0;
                        addr_q  <= BASE_ADDR;
                        state_q <= WAIT_VS;
                    end
                end
                WAIT_VS, CAPTURE: begin
                    // A vsync rise mid-capture aborts and restarts on the new frame.
                    if (vs_rise) begin
                        state_q <= CAPTURE;
                        addr_q  <= BASE_ADDR;
                        if (state_q == CAPTURE)
                            err_q <= 1'b1;
                    end
                    if (cap && in_win) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= base;
                        wr_data_q <= {i_red, i_green, i_blue};
                        addr_q    <= base + 32'd1;
                        if (last_px) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (i_continuous) begin
                        state_q <= WAIT_VS;
                        addr_q  <= BASE_ADDR;
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign o_wr_en      = wr_en_q;
    assign o_wr_addr    = wr_addr_q;
    assign o_wr_data    = wr_data_q;
    assign o_busy       = (state_q != IDLE);
    assign o_frame_done = done_q;
    assign o_err        = err_q;
    assign o_line_len   = len_q;

endmodule
